// File: rtl/seven_seg_capture.sv
// Captures the value shown on a multiplexed, active-low seven-segment display
// by sampling the segment/anode lines and decoding each digit once it settles.
module seven_seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic                    err_pulse,
  output logic [7:0]              err_count,
  output logic                    frame_done
);

  localparam int SW = 8 + NUM_DIGITS;
  localparam logic [0:0] SETTLE = 1'b0;
  localparam logic [0:0] HOLD   = 1'b1;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]         sample;
  logic [SW-1:0]         sample_in;
  logic [7:0]            sample_seg;
  logic [NUM_DIGITS-1:0] sample_an;
  logic [NUM_DIGITS-1:0] an_low;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_next;
  logic [7:0]            stable_cnt;
  logic [7:0]            cnt_next;
  logic [0:0]            state;
  logic                  changed;
  logic                  one_digit;
  logic                  capture;
  logic                  code_ok;
  logic [3:0]            code;
  int                    digit_idx;

  assign sample_in  = {seg, an};
  assign sample_seg = sample[SW-1 -: 8];
  assign sample_an  = sample[NUM_DIGITS-1:0];
  assign an_low     = ~sample_an;
  assign seen_next  = seen | an_low;

  // The counter compares the incoming sample with the registered one, so a
  // pattern held for STABLE_CYCLES edges is captured on the last of them.
  assign changed  = (sample_in != sample);
  assign cnt_next = changed ? 8'd0 :
                    (stable_cnt >= CNT_MAX) ? CNT_MAX : stable_cnt + 8'd1;
  assign capture  = (state == SETTLE) && !changed && (cnt_next == CNT_MAX);

  // Blanked or ghosted anodes (none or several low) are ignored silently.
  assign one_digit = (an_low != '0) &&
                     ((an_low & (an_low - NUM_DIGITS'(1))) == '0);

  always_comb begin
    code_ok = 1'b1;
    code    = 4'hF;
    unique case (sample_seg[6:0])
      7'h40:   code = 4'h0;
      7'h79:   code = 4'h1;
      7'h24:   code = 4'h2;
      7'h30:   code = 4'h3;
      7'h19:   code = 4'h4;
      7'h12:   code = 4'h5;
      7'h02:   code = 4'h6;
      7'h78:   code = 4'h7;
      7'h00:   code = 4'h8;
      7'h18:   code = 4'h9;
      7'h7F:   code = 4'hF;
      default: code_ok = 1'b0;
    endcase
  end

  always_comb begin
    digit_idx = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) digit_idx = i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample     <= '0;
      stable_cnt <= 8'd0;
      state      <= SETTLE;
      digits     <= '1;
      dp         <= '0;
      valid      <= '0;
      seen       <= '0;
      err_count  <= 8'd0;
      err_pulse  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sample     <= sample_in;
      err_pulse  <= 1'b0;
      frame_done <= 1'b0;
      if (clear) begin
        stable_cnt <= 8'd0;
        state      <= SETTLE;
        digits     <= '1;
        dp         <= '0;
        valid      <= '0;
        seen       <= '0;
        err_count  <= 8'd0;
      end else begin
        stable_cnt <= cnt_next;
        if (changed)      state <= SETTLE;
        else if (capture) state <= HOLD;
        if (capture && one_digit) begin
          if (code_ok) begin
            digits[4*digit_idx +: 4] <= code;
            dp[digit_idx]            <= ~sample_seg[7];
            valid[digit_idx]         <= 1'b1;
            // A completed frame restarts the seen mask on the same edge.
            if (&seen_next) begin
              frame_done <= 1'b1;
              seen       <= '0;
            end else begin
              seen <= seen_next;
            end
          end else begin
            valid[digit_idx] <= 1'b0;
            err_pulse        <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a run-length model.
module tb_seven_seg_capture;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    seg = 8'h00;
  logic [ND-1:0] an = '1;
  logic          clear = 1'b0;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp;
  logic [ND-1:0] valid;
  logic          err_pulse;
  logic [7:0]    err_count;
  logic          frame_done;

  int checks = 0;
  int fails  = 0;
  bit check_en = 1'b0;

  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_dp, m_valid, m_seen;
  logic            m_err_pulse, m_frame_done;
  logic [7:0]      m_err_count;
  logic [8+ND-1:0] hist[$];
  int              restart;

  always #5 clk = ~clk;

  seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .clear(clear),
    .digits(digits), .dp(dp), .valid(valid), .err_pulse(err_pulse),
    .err_count(err_count), .frame_done(frame_done)
  );

  function automatic logic [6:0] segPattern(input int idx);
    logic [6:0] pats [11];
    pats = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18, 7'h7F};
    return pats[idx];
  endfunction

  // Returns {decodable, code}.
  function automatic logic [4:0] decodeSeg(input logic [6:0] s);
    for (int i = 0; i < 11; i++) begin
      if (segPattern(i) == s) return {1'b1, (i == 10) ? 4'hF : 4'(i)};
    end
    return 5'h0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_digits = '1; m_dp = '0; m_valid = '0; m_seen = '0;
    m_err_pulse = 1'b0; m_frame_done = 1'b0; m_err_count = 8'd0;
    hist.delete();
    hist.push_back('0);
    restart = 0;
  endtask

  // A digit is taken when the same {seg,an} has been seen on exactly SC
  // consecutive edges since the last change, clear or reset.
  task automatic modelEdge();
    logic [8+ND-1:0] x;
    logic [ND-1:0]   low;
    logic [4:0]      dec;
    int              r, idx;
    x = {seg, an};
    m_err_pulse = 1'b0;
    m_frame_done = 1'b0;
    hist.push_back(x);
    if (clear) begin
      m_digits = '1; m_dp = '0; m_valid = '0; m_seen = '0; m_err_count = 8'd0;
      restart = hist.size() - 1;
    end else begin
      r = 1;
      for (int j = hist.size() - 2; j >= restart && r <= SC; j--) begin
        if (hist[j] == x) r++;
        else break;
      end
      low = ~x[ND-1:0];
      if (r == SC && $countones(low) == 1) begin
        idx = 0;
        for (int k = 0; k < ND; k++) if (low[k]) idx = k;
        dec = decodeSeg(x[ND+6:ND]);
        if (dec[4]) begin
          m_digits[4*idx +: 4] = dec[3:0];
          m_dp[idx] = ~x[ND+7];
          m_valid[idx] = 1'b1;
          m_seen[idx] = 1'b1;
          if (&m_seen) begin
            m_frame_done = 1'b1;
            m_seen = '0;
          end
        end else begin
          m_valid[idx] = 1'b0;
          m_err_pulse = 1'b1;
          if (m_err_count != 8'hFF) m_err_count = m_err_count + 8'd1;
        end
      end
    end
    if (hist.size() > 2*SC + 4) begin
      void'(hist.pop_front());
      if (restart > 0) restart--;
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelEdge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en && rst_n) begin
        checkOutput("model digits", 32'(digits), 32'(m_digits));
        checkOutput("model dp", 32'(dp), 32'(m_dp));
        checkOutput("model valid", 32'(valid), 32'(m_valid));
        checkOutput("model err_pulse", 32'(err_pulse), 32'(m_err_pulse));
        checkOutput("model err_count", 32'(err_count), 32'(m_err_count));
        checkOutput("model frame_done", 32'(frame_done), 32'(m_frame_done));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] s, input logic [ND-1:0] a, input int n);
    seg = s;
    an = a;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [ND-1:0] a;
    logic [7:0] s;
    int kind, hold;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    checkOutput("reset digits", 32'(digits), 32'hFFFF);
    checkOutput("reset valid", 32'(valid), 32'h0);
    checkOutput("reset err_count", 32'(err_count), 32'h0);

    // Basic capture timing: nothing after 3 edges, digit 0 = 2 on the 4th.
    applyStimulus(8'hA4, 4'b1110, 3);
    checkOutput("early valid", 32'(valid), 32'h0);
    applyStimulus(8'hA4, 4'b1110, 1);
    checkOutput("cap digit0", 32'(digits[3:0]), 32'h2);
    checkOutput("cap valid0", 32'(valid[0]), 32'h1);
    checkOutput("cap dp0", 32'(dp[0]), 32'h0);

    // Too-short hold never captures.
    applyStimulus(8'h12, 4'b1101, 3);
    applyStimulus(8'hFF, 4'b1111, 2);
    checkOutput("short hold valid", 32'(valid), 32'h1);

    // Full scan of all digits and the frame pulse.
    applyStimulus(8'h40, 4'b1110, 6);
    applyStimulus(8'h79, 4'b1101, 6);
    applyStimulus(8'h24, 4'b1011, 6);
    applyStimulus(8'h30, 4'b0111, 3);
    checkOutput("frame early", 32'(frame_done), 32'h0);
    applyStimulus(8'h30, 4'b0111, 1);
    checkOutput("frame pulse", 32'(frame_done), 32'h1);
    applyStimulus(8'h30, 4'b0111, 1);
    checkOutput("frame single", 32'(frame_done), 32'h0);
    applyStimulus(8'h30, 4'b0111, 1);
    checkOutput("scan digits", 32'(digits), 32'h3210);
    checkOutput("scan valid", 32'(valid), 32'hF);
    checkOutput("scan dp", 32'(dp), 32'hF);

    // Undecodable pattern and error counter saturation.
    applyStimulus(8'h55, 4'b1011, 4);
    checkOutput("err pulse", 32'(err_pulse), 32'h1);
    checkOutput("err count1", 32'(err_count), 32'h1);
    checkOutput("err valid2", 32'(valid[2]), 32'h0);
    checkOutput("err digit2", 32'(digits[11:8]), 32'h2);
    applyStimulus(8'hFF, 4'b1111, 1);
    checkOutput("err pulse end", 32'(err_pulse), 32'h0);
    for (int i = 0; i < 255; i++) begin
      applyStimulus(8'h55, 4'b1011, 4);
      applyStimulus(8'hFF, 4'b1111, 1);
    end
    checkOutput("err saturate", 32'(err_count), 32'hFF);

    // Ghosted and blanked anodes are ignored.
    applyStimulus(8'h40, 4'b0011, 10);
    applyStimulus(8'h40, 4'b1111, 10);
    checkOutput("ghost digits", 32'(digits), 32'h3210);
    checkOutput("ghost valid", 32'(valid), 32'hB);
    checkOutput("ghost err_count", 32'(err_count), 32'hFF);

    // Clear on the capture edge wins; capture follows once the count rebuilds.
    applyStimulus(8'h79, 4'b1110, 3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clear digits", 32'(digits), 32'hFFFF);
    checkOutput("clear valid", 32'(valid), 32'h0);
    checkOutput("clear err_count", 32'(err_count), 32'h0);
    checkOutput("clear err_pulse", 32'(err_pulse), 32'h0);
    checkOutput("clear frame", 32'(frame_done), 32'h0);
    applyStimulus(8'h79, 4'b1110, 2);
    checkOutput("post clear early", 32'(valid), 32'h0);
    applyStimulus(8'h79, 4'b1110, 1);
    checkOutput("post clear digit0", 32'(digits[3:0]), 32'h1);

    // Reset mid-count discards progress; a full window is needed again.
    applyStimulus(8'h30, 4'b1101, 2);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    applyStimulus(8'h30, 4'b1101, 3);
    checkOutput("rst window early", 32'(valid), 32'h0);
    applyStimulus(8'h30, 4'b1101, 1);
    checkOutput("rst window valid1", 32'(valid[1]), 32'h1);
    checkOutput("rst window digit1", 32'(digits[7:4]), 32'h3);

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6)      a = ~(ND'(1) << $urandom_range(0, ND-1));
      else if (kind == 7) a = '1;
      else if (kind == 8) a = ND'($urandom_range(0, 15));
      else                a = 4'b0011;
      kind = $urandom_range(0, 9);
      if (kind <= 7)      s = {1'($urandom_range(0, 1)), segPattern($urandom_range(0, 10))};
      else if (kind == 8) s = 8'h55;
      else                s = 8'($urandom_range(0, 255));
      seg = s;
      an = a;
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        clear = ($urandom_range(0, 49) == 0);
        @(negedge clk);
      end
      clear = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
